// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and default vectors for the CatCORE program-counter unit
package pc_pkg;

  typedef enum logic {ST_RUN, ST_HALTED} state_t;

  typedef enum logic [2:0] {SEL_SEQ, SEL_BR, SEL_JMP, SEL_EPC, SEL_VEC, SEL_HOLD} sel_t;

  localparam int          DEF_WIDTH        = 32;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_IRQ_VECTOR   = 32'h0000_0100;
  localparam int          DEF_STEP         = 1;

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational priority encoder choosing the next PC and the interrupt return address
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(DEF_IRQ_VECTOR)
) (
  input  state_t           state,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             reti,
  input  logic             irq_req,
  input  logic             irq_en,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] pc_plus,
  input  logic [WIDTH-1:0] epc,
  output sel_t             sel,
  output logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] ret_addr
);

  sel_t             flow_sel;
  logic [WIDTH-1:0] flow_addr;

  // flow_sel is what the program would do if no stall, interrupt or halt intervened;
  // it also defines the address saved into EPC on interrupt entry from RUN.
  always_comb begin
    flow_sel = SEL_SEQ;
    if (reti)              flow_sel = SEL_EPC;
    else if (jump)         flow_sel = SEL_JMP;
    else if (branch_taken) flow_sel = SEL_BR;

    flow_addr = pc_plus;
    case (flow_sel)
      SEL_EPC: flow_addr = epc;
      SEL_JMP: flow_addr = jump_target;
      SEL_BR:  flow_addr = branch_target;
      default: flow_addr = pc_plus;
    endcase
  end

  always_comb begin
    sel = flow_sel;
    if (state == ST_HALTED) begin
      sel = (irq_req && irq_en) ? SEL_VEC : SEL_HOLD;
    end else if (stall) begin
      sel = SEL_HOLD;
    end else if (irq_req && irq_en) begin
      sel = SEL_VEC;
    end else if (halt) begin
      sel = SEL_HOLD;
    end

    nxt = flow_addr;
    case (sel)
      SEL_VEC:  nxt = IRQ_VECTOR;
      SEL_HOLD: nxt = pc;
      default:  nxt = flow_addr;
    endcase

    ret_addr = (state == ST_HALTED) ? pc : flow_addr;
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage program counter with stall, halt/resume and single-level interrupt entry
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] IRQ_VECTOR   = WIDTH'(DEF_IRQ_VECTOR),
  parameter int               STEP         = DEF_STEP
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             resume,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             reti,
  input  logic             ie_set,
  input  logic             ie_clr,
  input  logic             irq_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic [WIDTH-1:0] epc,
  output logic             irq_en,
  output logic             irq_ack,
  output logic             halted
);

  state_t           state, state_nxt;
  sel_t             sel;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] ret_addr;
  logic             take_irq;
  logic             reti_taken;
  logic             frozen;
  logic             ie_nxt;

  assign pc_plus    = pc + WIDTH'(STEP);
  assign halted     = (state == ST_HALTED);
  assign take_irq   = (sel == SEL_VEC);
  assign reti_taken = (sel == SEL_EPC);
  assign frozen     = (state == ST_RUN) && stall;

  pc_next_sel #(
    .WIDTH      (WIDTH),
    .IRQ_VECTOR (IRQ_VECTOR)
  ) u_next_sel (
    .state         (state),
    .stall         (stall),
    .halt          (halt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .reti          (reti),
    .irq_req       (irq_req),
    .irq_en        (irq_en),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .epc           (epc),
    .sel           (sel),
    .nxt           (nxt),
    .ret_addr      (ret_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Interrupt entry wakes a halted core; halt in RUN loses to stall and to entry.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    if (!stall && !take_irq && halt) state_nxt = ST_HALTED;
      ST_HALTED: if (take_irq || resume)          state_nxt = ST_RUN;
    endcase
  end

  // Clear beats set, and entry beats both; reti re-enables unless cleared the same cycle.
  always_comb begin
    ie_nxt = irq_en;
    if (!frozen) begin
      if (take_irq)                  ie_nxt = 1'b0;
      else if (ie_clr)               ie_nxt = 1'b0;
      else if (ie_set || reti_taken) ie_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= RESET_VECTOR;
      epc     <= '0;
      irq_en  <= 1'b0;
      irq_ack <= 1'b0;
    end else begin
      pc      <= nxt;
      irq_en  <= ie_nxt;
      irq_ack <= take_irq;
      if (take_irq) epc <= ret_addr;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - table-driven scoreboard bench for pc_unit
module tb_pc_unit;

  localparam logic [8:0] S   = 9'h100;
  localparam logic [8:0] H   = 9'h080;
  localparam logic [8:0] R   = 9'h040;
  localparam logic [8:0] B   = 9'h020;
  localparam logic [8:0] J   = 9'h010;
  localparam logic [8:0] RT  = 9'h008;
  localparam logic [8:0] IS  = 9'h004;
  localparam logic [8:0] IC  = 9'h002;
  localparam logic [8:0] IRQ = 9'h001;

  typedef struct {
    string       name;
    logic [8:0]  ctl;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] pc;
    logic [31:0] epc;
    logic        ie;
    logic        ack;
    logic        hlt;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset, stall, halt, resume, branch_taken, jump, reti, ie_set, ie_clr, irq_req;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc, pc_plus, epc;
  logic        irq_en, irq_ack, halted;

  logic        reset8, jump8;
  logic [7:0]  jt8;
  logic [7:0]  pc8, pc_plus8, epc8;
  logic        irq_en8, irq_ack8, halted8;

  int pass_cnt = 0;
  int total_cnt = 0;

  vec_t tbl[$];
  vec_t sb[$];

  always #5 clock = ~clock;

  pc_unit dut (
    .clock(clock), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .reti(reti),
    .ie_set(ie_set), .ie_clr(ie_clr), .irq_req(irq_req),
    .pc(pc), .pc_plus(pc_plus), .epc(epc),
    .irq_en(irq_en), .irq_ack(irq_ack), .halted(halted)
  );

  pc_unit #(.WIDTH(8), .RESET_VECTOR(8'hF0), .IRQ_VECTOR(8'h80), .STEP(1)) dut8 (
    .clock(clock), .reset(reset8), .stall(1'b0), .halt(1'b0), .resume(1'b0),
    .branch_taken(1'b0), .branch_target(8'h00),
    .jump(jump8), .jump_target(jt8), .reti(1'b0),
    .ie_set(1'b0), .ie_clr(1'b0), .irq_req(1'b0),
    .pc(pc8), .pc_plus(pc_plus8), .epc(epc8),
    .irq_en(irq_en8), .irq_ack(irq_ack8), .halted(halted8)
  );

  function automatic vec_t mk(input string n, input logic [8:0] c, input logic [31:0] bt,
                              input logic [31:0] jt, input logic [31:0] p, input logic [31:0] e,
                              input logic ie, input logic ack, input logic h);
    vec_t v;
    v.name = n; v.ctl = c; v.bt = bt; v.jt = jt;
    v.pc = p; v.epc = e; v.ie = ie; v.ack = ack; v.hlt = h;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    stall = v.ctl[8]; halt = v.ctl[7]; resume = v.ctl[6]; branch_taken = v.ctl[5];
    jump = v.ctl[4]; reti = v.ctl[3]; ie_set = v.ctl[2]; ie_clr = v.ctl[1]; irq_req = v.ctl[0];
    branch_target = v.bt; jump_target = v.jt;
    sb.push_back(v);
    tick();
    e = sb.pop_front();
    chk({e.name, ".pc"}, pc, e.pc);
    chk({e.name, ".pc_plus"}, pc_plus, e.pc + 32'd1);
    chk({e.name, ".epc"}, epc, e.epc);
    chk({e.name, ".irq_en"}, {31'd0, irq_en}, {31'd0, e.ie});
    chk({e.name, ".irq_ack"}, {31'd0, irq_ack}, {31'd0, e.ack});
    chk({e.name, ".halted"}, {31'd0, halted}, {31'd0, e.hlt});
  endtask

  initial begin
    reset = 1'b1; reset8 = 1'b1; jump8 = 1'b0; jt8 = 8'h00;
    stall = 0; halt = 0; resume = 0; branch_taken = 0; jump = 0; reti = 0;
    ie_set = 0; ie_clr = 0; irq_req = 0; branch_target = 0; jump_target = 0;

    tbl.push_back(mk("seq1",        0,       0,  0,  32'h1,   0,  0, 0, 0));
    tbl.push_back(mk("seq2",        0,       0,  0,  32'h2,   0,  0, 0, 0));
    tbl.push_back(mk("seq3",        0,       0,  0,  32'h3,   0,  0, 0, 0));
    tbl.push_back(mk("seq4",        0,       0,  0,  32'h4,   0,  0, 0, 0));
    tbl.push_back(mk("jmp10",       J,       0,  10, 32'd10,  0,  0, 0, 0));
    tbl.push_back(mk("jmp_over_br", J|B,     20, 40, 32'd40,  0,  0, 0, 0));
    tbl.push_back(mk("stall_jmp",   S|J,     0,  99, 32'd40,  0,  0, 0, 0));
    tbl.push_back(mk("stall_ieset", S|IS,    0,  0,  32'd40,  0,  0, 0, 0));
    tbl.push_back(mk("jmp7_ieset",  J|IS,    0,  7,  32'd7,   0,  1, 0, 0));
    tbl.push_back(mk("irq_br",      IRQ|B,   30, 0,  32'h100, 30, 0, 1, 0));
    tbl.push_back(mk("isr_seq",     0,       0,  0,  32'h101, 30, 0, 0, 0));
    tbl.push_back(mk("irq_masked",  IRQ,     0,  0,  32'h102, 30, 0, 0, 0));
    tbl.push_back(mk("reti",        RT,      0,  0,  32'd30,  30, 1, 0, 0));
    tbl.push_back(mk("after_reti",  0,       0,  0,  32'd31,  30, 1, 0, 0));
    tbl.push_back(mk("irq_ov_halt", IRQ|J|H, 0,  55, 32'h100, 55, 0, 1, 0));
    tbl.push_back(mk("reti_clr",    RT|IC,   0,  0,  32'd55,  55, 0, 0, 0));
    tbl.push_back(mk("set_clr",     IS|IC,   0,  0,  32'd56,  55, 0, 0, 0));
    tbl.push_back(mk("jmp5",        J,       0,  5,  32'd5,   55, 0, 0, 0));
    tbl.push_back(mk("halt",        H,       0,  0,  32'd5,   55, 0, 0, 1));
    tbl.push_back(mk("h_jmp",       J,       0,  77, 32'd5,   55, 0, 0, 1));
    tbl.push_back(mk("h_misc",      S|B|RT,  9,  0,  32'd5,   55, 0, 0, 1));
    tbl.push_back(mk("h_irq_mask",  IRQ,     0,  0,  32'd5,   55, 0, 0, 1));
    tbl.push_back(mk("h_halt_res",  H|R,     0,  0,  32'd5,   55, 0, 0, 0));
    tbl.push_back(mk("res_seq",     0,       0,  0,  32'd6,   55, 0, 0, 0));
    tbl.push_back(mk("jmp5b",       J,       0,  5,  32'd5,   55, 0, 0, 0));
    tbl.push_back(mk("halt_ieset",  H|IS,    0,  0,  32'd5,   55, 1, 0, 1));
    tbl.push_back(mk("h_irq",       IRQ,     0,  0,  32'h100, 5,  0, 1, 0));
    tbl.push_back(mk("stall_ack",   S,       0,  0,  32'h100, 5,  0, 0, 0));
    tbl.push_back(mk("isr_seq2",    0,       0,  0,  32'h101, 5,  0, 0, 0));
    tbl.push_back(mk("stall_halt",  S|H,     0,  0,  32'h101, 5,  0, 0, 0));
    tbl.push_back(mk("halt_irqm",   H|IRQ,   0,  0,  32'h101, 5,  0, 0, 1));
    tbl.push_back(mk("resume",      R,       0,  0,  32'h101, 5,  0, 0, 0));
    tbl.push_back(mk("seq_ieset",   IS,      0,  0,  32'h102, 5,  1, 0, 0));

    tick();
    chk("reset.pc", pc, 32'h0);
    chk("reset.pc_plus", pc_plus, 32'h1);
    chk("reset.epc", epc, 32'h0);
    chk("reset.irq_en", {31'd0, irq_en}, 32'd0);
    chk("reset.irq_ack", {31'd0, irq_ack}, 32'd0);
    chk("reset.halted", {31'd0, halted}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    apply(mk("long_jmp5", J, 0, 5, 32'd5, 5, 1, 0, 0));
    apply(mk("long_halt", H, 0, 0, 32'd5, 5, 1, 0, 1));
    for (int i = 0; i < 10; i++)
      apply(mk("long_hold", (i % 2 == 0) ? J : 9'h000, 0, 200 + i, 32'd5, 5, 1, 0, 1));
    apply(mk("long_resume", R, 0, 0, 32'd5, 5, 1, 0, 0));
    apply(mk("long_seq", 0, 0, 0, 32'd6, 5, 1, 0, 0));
    apply(mk("stall_irq", S|IRQ, 0, 0, 32'd6, 5, 1, 0, 0));
    apply(mk("irq_after_st", IRQ, 0, 0, 32'h100, 7, 0, 1, 0));
    apply(mk("isr_ieset", IS, 0, 0, 32'h101, 7, 1, 0, 0));

    reset = 1'b1; stall = 1'b1; halt = 1'b1; jump = 1'b1; jump_target = 32'd99; irq_req = 1'b1;
    tick();
    chk("rst_stall.pc", pc, 32'h0);
    chk("rst_stall.epc", epc, 32'h0);
    chk("rst_stall.irq_en", {31'd0, irq_en}, 32'd0);
    chk("rst_stall.irq_ack", {31'd0, irq_ack}, 32'd0);
    chk("rst_stall.halted", {31'd0, halted}, 32'd0);
    reset = 1'b0; stall = 1'b0; halt = 1'b0; jump = 1'b0; irq_req = 1'b0;

    chk("w8.reset_pc", {24'd0, pc8}, 32'hF0);
    reset8 = 1'b0; jump8 = 1'b1; jt8 = 8'hFE;
    tick();
    chk("w8.jmp_pc", {24'd0, pc8}, 32'hFE);
    jump8 = 1'b0;
    tick();
    chk("w8.pc_ff", {24'd0, pc8}, 32'hFF);
    chk("w8.pc_plus_wrap", {24'd0, pc_plus8}, 32'h00);
    tick();
    chk("w8.wrap_pc", {24'd0, pc8}, 32'h00);
    chk("w8.halted", {31'd0, halted8}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
